cv32e40p_cv_x_if_dispatcher: RTL and testbench
==============================================

// Module: cv32e40p_cv_x_if_dispatcher
// PURPOSE
// - Parametrised X-interface offload dispatcher between the core X-request/response channels and NumAcc accelerators.
// - Predecodes each offloaded instruction by major opcode and routes it to one accelerator channel.
// - Tracks outstanding instructions per channel and round-robin arbitrates the accelerator responses.
// - Buffers the arbitrated responses in a FIFO that drives the core's X-response channel.
// PARAMETERS
// - NumAcc         2          number of accelerator channels (1..8)
// - NumRs          3          source operands per request
// - DataWidth      32         operand/result width
// - MaxOutstanding 4          max in-flight instructions per channel (>=1)
// - RspDepth       2          response FIFO entries (>=1)
// - AccOpcode      {7'h53,7'h0B}  [NumAcc][6:0] major opcode owned by channel i
// - AccWriteback   '1         [NumAcc] channel i writes back to the integer RF
// PORTS
// - clk_i           in   1                  clock
// - rst_i           in   1                  asynchronous reset, active-high
// - x_q_valid_i     in   1                  offload request valid
// - x_q_ready_o     out  1                  offload request ready
// - x_q_instr_i     in   32                 instruction word
// - x_q_rs_i        in   NumRs*DataWidth    operands, rs[k] at [k*DataWidth +: DataWidth]
// - x_q_rs_valid_i  in   NumRs              operand valid flags
// - x_k_accept_o    out  1                  accepted (valid with the q handshake)
// - x_k_writeback_o out  1                  result will be written back
// - x_p_valid_o     out  1                  response valid
// - x_p_ready_i     in   1                  response ready
// - x_p_rd_o        out  5                  destination register
// - x_p_data_o      out  DataWidth          result
// - x_p_error_o     out  1                  accelerator error
// - c_q_valid_o     out  NumAcc             per-channel request valid
// - c_q_ready_i     in   NumAcc             per-channel request ready
// - c_q_instr_o     out  32                 broadcast instruction word
// - c_q_rs_o        out  NumRs*DataWidth    broadcast operands
// - c_p_valid_i     in   NumAcc             per-channel response valid
// - c_p_ready_o     out  NumAcc             per-channel response ready
// - c_p_rd_i        in   NumAcc*5           per-channel rd
// - c_p_data_i      in   NumAcc*DataWidth   per-channel result
// - c_p_error_i     in   NumAcc             per-channel error
// BEHAVIOUR
// - Reset: all counters 0, FIFO empty, RR pointer 0.
//   - x_p_valid_o=0, c_q_valid_o=0, c_p_ready_o=0.
//   - x_q_ready_o=0, x_k_* =0 while rst_i is high.
//   - A reset mid-operation drops in-flight state without responses.
// - Predecode (comb): sel = lowest i with instr[6:0]==AccOpcode[i]; hit = any match.
// - Request path (comb, zero latency):
//   - No hit: x_q_ready_o=1 when x_q_valid_i is high, x_k_accept_o=0, no c_q_valid.
//   - Hit: c_q_valid_o[sel] = x_q_valid_i & &x_q_rs_valid_i & cnt[sel]<MaxOutstanding.
//   - Hit: x_q_ready_o = c_q_ready_i[sel] & c_q_valid_o[sel]; x_k_accept_o=1; x_k_writeback_o=AccWriteback[sel].
//   - x_k_* are meaningful only while x_q_valid_i is high.
//   - Operands incomplete or channel full: hold ready=0, no rejection.
// - Outstanding counters cnt[i], width $clog2(MaxOutstanding+1):
//   - +1 on the c_q handshake of channel i; -1 on the c_p handshake of channel i.
//   - Both in one cycle: unchanged.
//   - Never exceeds MaxOutstanding.
//   - A c_p_valid with cnt==0 is a protocol error: flag it by assertion, do not decrement.
// - Response arbitration, one grant per cycle:
//   - Round-robin starting at ptr; grant only when the FIFO can push.
//   - c_p_ready_o[g]=1 for the granted g only.
//   - On a handshake, ptr <= (g+1) mod NumAcc; otherwise ptr holds.
// - Response FIFO, RspDepth entries {rd,data,error}:
//   - Push allowed when not full, or when full and popping in the same cycle.
//   - Pop on x_p_valid_o & x_p_ready_i; x_p_valid_o = !empty; outputs come from the head.
//   - Accelerator response to x_p_valid_o: 1 cycle minimum.
//   - Pointers wrap modulo RspDepth; use an explicit count, no power-of-2 requirement.
// - Ordering: in-order within a channel; no ordering across channels.
// STRUCTURE
// - cv_x_if_pkg: x_rsp_entry_t {rd, data, error}, opcode constants, clog2-based count types.
// - Sub-module cv32e40p_cv_x_if_rsp_fifo: parametrised type/depth FIFO with full/empty/count.
// - Top level holds predecode, counters and the RR arbiter.
// TESTING
// - Default params, instr opcode 0x53, all rs_valid, c_q_ready_i=01 -> c_q_valid_o=01, same-cycle q handshake, accept=1, cnt[0]=1.
// - Opcode 0x33 (no match) -> x_q_ready_o=1, x_k_accept_o=0, c_q_valid_o=00, counters unchanged.
// - Five back-to-back 0x53 requests, no responses -> fifth stalls with ready=0 until one c_p handshake on ch0.
// - c_p_valid_i=11 held for 4 cycles, x_p_ready_i=1 -> grants alternate ch0,ch1,ch0,ch1; x_p_data_o order matches.
// - x_p_ready_i=0, 3 responses, RspDepth=2 -> FIFO full after 2, c_p_ready_o=00; ready=1 -> push and pop in the same cycle.
// - rst_i asserted with cnt[0]=3 and FIFO holding 1 entry -> next cycle x_p_valid_o=0, cnt=0; first later grant goes to ch0.

Source files
------------

// File: rtl/cv_x_if_pkg.sv
// Shared types, opcode constants and width helpers for the CV-X-IF offload dispatcher.
package cv_x_if_pkg;

    localparam logic [6:0] OPCODE_OP_FP   = 7'h53;
    localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPCODE_OP      = 7'h33;

    localparam int XDataWidth = 32;

    typedef struct packed {
        logic [4:0]            rd;
        logic [XDataWidth-1:0] data;
        logic                  error;
    } x_rsp_entry_t;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_cv_x_if_rsp_fifo.sv
// Response FIFO with explicit occupancy count, so depth need not be a power of two.
module cv32e40p_cv_x_if_rsp_fifo
    import cv_x_if_pkg::*;
#(
    parameter type T     = x_rsp_entry_t,
    parameter int  Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int PtrW = idx_width(Depth);
    localparam int CntW = cnt_width(Depth);

    T                r_mem [Depth];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;
    logic [CntW-1:0] r_count;
    logic            w_doPush;
    logic            w_doPop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_doPop  = i_pop & !o_empty;
    assign w_doPush = i_push & (!o_full | w_doPop);

    always_ff @(posedge clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= (r_wrPtr == PtrW'(Depth - 1)) ? '0 : r_wrPtr + PtrW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= (r_rdPtr == PtrW'(Depth - 1)) ? '0 : r_rdPtr + PtrW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/cv32e40p_cv_x_if_dispatcher.sv
// X-interface offload dispatcher: opcode predecode, per-channel outstanding
// tracking, round-robin response arbitration and a response FIFO to the core.
module cv32e40p_cv_x_if_dispatcher
    import cv_x_if_pkg::*;
#(
    parameter int                NumAcc         = 2,
    parameter int                NumRs          = 3,
    parameter int                DataWidth      = 32,
    parameter int                MaxOutstanding = 4,
    parameter int                RspDepth       = 2,
    parameter logic [6:0]        AccOpcode [NumAcc] = '{OPCODE_OP_FP, OPCODE_CUSTOM0},
    parameter logic [NumAcc-1:0] AccWriteback   = '1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       x_q_valid_i,
    output logic                       x_q_ready_o,
    input  logic [31:0]                x_q_instr_i,
    input  logic [NumRs*DataWidth-1:0] x_q_rs_i,
    input  logic [NumRs-1:0]           x_q_rs_valid_i,
    output logic                       x_k_accept_o,
    output logic                       x_k_writeback_o,
    output logic                       x_p_valid_o,
    input  logic                       x_p_ready_i,
    output logic [4:0]                 x_p_rd_o,
    output logic [DataWidth-1:0]       x_p_data_o,
    output logic                       x_p_error_o,
    output logic [NumAcc-1:0]          c_q_valid_o,
    input  logic [NumAcc-1:0]          c_q_ready_i,
    output logic [31:0]                c_q_instr_o,
    output logic [NumRs*DataWidth-1:0] c_q_rs_o,
    input  logic [NumAcc-1:0]          c_p_valid_i,
    output logic [NumAcc-1:0]          c_p_ready_o,
    input  logic [NumAcc*5-1:0]        c_p_rd_i,
    input  logic [NumAcc*DataWidth-1:0] c_p_data_i,
    input  logic [NumAcc-1:0]          c_p_error_i
);

    localparam int CntW     = cnt_width(MaxOutstanding);
    localparam int SelW     = idx_width(NumAcc);
    localparam int FifoCntW = cnt_width(RspDepth);

    typedef struct packed {
        logic [4:0]           rd;
        logic [DataWidth-1:0] data;
        logic                 error;
    } rsp_entry_t;

    logic                w_hit;
    logic [SelW-1:0]     w_sel;
    logic                w_chanOk;
    logic [NumAcc-1:0]   w_inc;
    logic [NumAcc-1:0]   w_dec;
    logic [CntW-1:0]     r_cnt [NumAcc];
    logic [SelW-1:0]     r_ptr;
    logic [SelW-1:0]     w_idx;
    logic [SelW-1:0]     w_gnt;
    logic                w_gntValid;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [FifoCntW-1:0] w_rspCount;
    rsp_entry_t          w_pushEntry;
    rsp_entry_t          w_headEntry;

    // Descending scan so the lowest matching channel wins.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NumAcc - 1; i >= 0; i--) begin
            if (x_q_instr_i[6:0] == AccOpcode[i]) begin
                w_hit = 1'b1;
                w_sel = SelW'(i);
            end
        end
    end

    assign w_chanOk = !rst_i & w_hit & x_q_valid_i & (&x_q_rs_valid_i)
                    & (r_cnt[w_sel] < CntW'(MaxOutstanding));

    always_comb begin
        c_q_valid_o        = '0;
        c_q_valid_o[w_sel] = w_chanOk;
    end

    // Unclaimed opcodes are consumed immediately so the core can raise its own exception.
    assign x_q_ready_o     = !rst_i & (w_hit ? (c_q_ready_i[w_sel] & c_q_valid_o[w_sel]) : x_q_valid_i);
    assign x_k_accept_o    = !rst_i & w_hit;
    assign x_k_writeback_o = !rst_i & w_hit & AccWriteback[w_sel];
    assign c_q_instr_o     = x_q_instr_i;
    assign c_q_rs_o        = x_q_rs_i;

    always_comb begin
        for (int i = 0; i < NumAcc; i++) begin
            w_inc[i] = c_q_valid_o[i] & c_q_ready_i[i];
            w_dec[i] = c_p_valid_i[i] & c_p_ready_o[i] & (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumAcc; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumAcc; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CntW'(1);
                end else if (!w_inc[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - CntW'(1);
                end
            end
        end
    end

    // Round-robin search starting at r_ptr; descending loop gives offset 0 top priority.
    always_comb begin
        w_gntValid = 1'b0;
        w_gnt      = r_ptr;
        w_idx      = '0;
        for (int k = NumAcc - 1; k >= 0; k--) begin
            w_idx = SelW'((int'(r_ptr) + k) % NumAcc);
            if (c_p_valid_i[w_idx]) begin
                w_gntValid = 1'b1;
                w_gnt      = w_idx;
            end
        end
    end

    assign w_pop = x_p_valid_o & x_p_ready_i;

    always_comb begin
        c_p_ready_o = '0;
        if (!rst_i && w_gntValid && (!w_full || w_pop)) begin
            c_p_ready_o[w_gnt] = 1'b1;
        end
    end

    assign w_push            = |(c_p_ready_o & c_p_valid_i);
    assign w_pushEntry.rd    = c_p_rd_i[int'(w_gnt)*5 +: 5];
    assign w_pushEntry.data  = c_p_data_i[int'(w_gnt)*DataWidth +: DataWidth];
    assign w_pushEntry.error = c_p_error_i[w_gnt];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= (w_gnt == SelW'(NumAcc - 1)) ? '0 : w_gnt + SelW'(1);
        end
    end

    cv32e40p_cv_x_if_rsp_fifo #(
        .T     (rsp_entry_t),
        .Depth (RspDepth)
    ) u_rspFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  (w_pushEntry),
        .i_pop   (w_pop),
        .o_data  (w_headEntry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_rspCount)
    );

    assign x_p_valid_o = !w_empty;
    assign x_p_rd_o    = w_headEntry.rd;
    assign x_p_data_o  = w_headEntry.data;
    assign x_p_error_o = w_headEntry.error;

    // A response on a channel with nothing outstanding is an accelerator protocol violation.
    for (genvar i = 0; i < NumAcc; i++) begin : g_chk
        a_noSpuriousRsp: assert property (@(posedge clk_i) disable iff (rst_i)
            !(c_p_valid_i[i] && (r_cnt[i] == '0)));
        a_cntBound: assert property (@(posedge clk_i) disable iff (rst_i)
            r_cnt[i] <= CntW'(MaxOutstanding));
    end

    a_fifoBound: assert property (@(posedge clk_i) disable iff (rst_i)
        w_rspCount <= FifoCntW'(RspDepth));

endmodule

// File: tb/tb_cv32e40p_cv_x_if_dispatcher.sv
// Directed bench for the X-interface dispatcher with default parameters:
// channel 0 owns opcode 0x53, channel 1 owns 0x0B.
module tb_cv32e40p_cv_x_if_dispatcher;

    localparam int NumAcc    = 2;
    localparam int NumRs     = 3;
    localparam int DataWidth = 32;

    localparam logic [31:0] InstrCh0  = 32'h0000_0053;
    localparam logic [31:0] InstrCh1  = 32'h0000_000B;
    localparam logic [31:0] InstrNone = 32'h0000_0033;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic                        x_q_valid_i;
    logic                        x_q_ready_o;
    logic [31:0]                 x_q_instr_i;
    logic [NumRs*DataWidth-1:0]  x_q_rs_i;
    logic [NumRs-1:0]            x_q_rs_valid_i;
    logic                        x_k_accept_o;
    logic                        x_k_writeback_o;
    logic                        x_p_valid_o;
    logic                        x_p_ready_i;
    logic [4:0]                  x_p_rd_o;
    logic [DataWidth-1:0]        x_p_data_o;
    logic                        x_p_error_o;
    logic [NumAcc-1:0]           c_q_valid_o;
    logic [NumAcc-1:0]           c_q_ready_i;
    logic [31:0]                 c_q_instr_o;
    logic [NumRs*DataWidth-1:0]  c_q_rs_o;
    logic [NumAcc-1:0]           c_p_valid_i;
    logic [NumAcc-1:0]           c_p_ready_o;
    logic [NumAcc*5-1:0]         c_p_rd_i;
    logic [NumAcc*DataWidth-1:0] c_p_data_i;
    logic [NumAcc-1:0]           c_p_error_i;

    int checks   = 0;
    int failures = 0;

    cv32e40p_cv_x_if_dispatcher dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .x_q_valid_i     (x_q_valid_i),
        .x_q_ready_o     (x_q_ready_o),
        .x_q_instr_i     (x_q_instr_i),
        .x_q_rs_i        (x_q_rs_i),
        .x_q_rs_valid_i  (x_q_rs_valid_i),
        .x_k_accept_o    (x_k_accept_o),
        .x_k_writeback_o (x_k_writeback_o),
        .x_p_valid_o     (x_p_valid_o),
        .x_p_ready_i     (x_p_ready_i),
        .x_p_rd_o        (x_p_rd_o),
        .x_p_data_o      (x_p_data_o),
        .x_p_error_o     (x_p_error_o),
        .c_q_valid_o     (c_q_valid_o),
        .c_q_ready_i     (c_q_ready_i),
        .c_q_instr_o     (c_q_instr_o),
        .c_q_rs_o        (c_q_rs_o),
        .c_p_valid_i     (c_p_valid_i),
        .c_p_ready_o     (c_p_ready_o),
        .c_p_rd_i        (c_p_rd_i),
        .c_p_data_i      (c_p_data_i),
        .c_p_error_i     (c_p_error_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic driveIdle();
        x_q_valid_i    = 1'b0;
        x_q_instr_i    = '0;
        x_q_rs_i       = '0;
        x_q_rs_valid_i = '0;
        x_p_ready_i    = 1'b0;
        c_q_ready_i    = '0;
        c_p_valid_i    = '0;
        c_p_rd_i       = '0;
        c_p_data_i     = '0;
        c_p_error_i    = '0;
    endtask

    task automatic applyReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        driveIdle();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One request cycle on the channel selected by mask, expecting an immediate handshake.
    task automatic issue(input logic [31:0] instr, input logic [1:0] mask);
        @(negedge clk_i);
        x_q_valid_i    = 1'b1;
        x_q_instr_i    = instr;
        x_q_rs_valid_i = 3'b111;
        c_q_ready_i    = mask;
        #1;
        checks++;
        if (x_q_ready_o !== 1'b1 || c_q_valid_o !== mask) begin
            failures++;
            $display("[TB] FAIL issue: ready=%b c_q_valid=%b, expected ready=1 c_q_valid=%b",
                     x_q_ready_o, c_q_valid_o, mask);
        end
        @(posedge clk_i);
        #1;
        x_q_valid_i = 1'b0;
        c_q_ready_i = '0;
    endtask

    task automatic test_reset();
        rst_i          = 1'b1;
        driveIdle();
        x_q_valid_i    = 1'b1;
        x_q_instr_i    = InstrCh0;
        x_q_rs_valid_i = 3'b111;
        c_q_ready_i    = 2'b01;
        c_p_valid_i    = 2'b11;
        x_p_ready_i    = 1'b1;
        #2;
        checks++;
        if (x_q_ready_o !== 1'b0 || x_k_accept_o !== 1'b0 || x_k_writeback_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_req: ready=%b accept=%b wb=%b, expected 0 0 0",
                     x_q_ready_o, x_k_accept_o, x_k_writeback_o);
        end
        checks++;
        if (c_q_valid_o !== 2'b00 || c_p_ready_o !== 2'b00 || x_p_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_chan: c_q_valid=%b c_p_ready=%b x_p_valid=%b, expected 00 00 0",
                     c_q_valid_o, c_p_ready_o, x_p_valid_o);
        end
        @(negedge clk_i);
        driveIdle();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (x_p_valid_o !== 1'b0 || dut.r_cnt[0] !== 3'd0 || dut.r_cnt[1] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: x_p_valid=%b cnt0=%0d cnt1=%0d, expected 0 0 0",
                     x_p_valid_o, dut.r_cnt[0], dut.r_cnt[1]);
        end
    endtask

    task automatic test_offload_hit();
        logic [31:0]                instr;
        logic [NumRs*DataWidth-1:0] rs;
        instr = InstrCh0 | 32'h0000_0280;
        rs    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        @(negedge clk_i);
        x_q_valid_i    = 1'b1;
        x_q_instr_i    = instr;
        x_q_rs_i       = rs;
        x_q_rs_valid_i = 3'b011;
        c_q_ready_i    = 2'b01;
        #1;
        checks++;
        if (c_q_valid_o !== 2'b00 || x_q_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hit_rs_incomplete: c_q_valid=%b ready=%b, expected 00 0",
                     c_q_valid_o, x_q_ready_o);
        end
        x_q_rs_valid_i = 3'b111;
        c_q_ready_i    = 2'b00;
        #1;
        checks++;
        if (c_q_valid_o !== 2'b01 || x_q_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hit_chan_busy: c_q_valid=%b ready=%b, expected 01 0",
                     c_q_valid_o, x_q_ready_o);
        end
        c_q_ready_i = 2'b01;
        #1;
        checks++;
        if (c_q_valid_o !== 2'b01 || x_q_ready_o !== 1'b1 || x_k_accept_o !== 1'b1
            || x_k_writeback_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hit_handshake: c_q_valid=%b ready=%b accept=%b wb=%b, expected 01 1 1 1",
                     c_q_valid_o, x_q_ready_o, x_k_accept_o, x_k_writeback_o);
        end
        checks++;
        if (c_q_instr_o !== instr || c_q_rs_o !== rs) begin
            failures++;
            $display("[TB] FAIL hit_broadcast: instr=%h rs=%h, expected %h %h",
                     c_q_instr_o, c_q_rs_o, instr, rs);
        end
        @(posedge clk_i);
        #1;
        driveIdle();
        checks++;
        if (dut.r_cnt[0] !== 3'd1) begin
            failures++;
            $display("[TB] FAIL hit_cnt0: got %0d expected 1", dut.r_cnt[0]);
        end
    endtask

    task automatic test_no_match();
        @(negedge clk_i);
        x_q_valid_i    = 1'b1;
        x_q_instr_i    = InstrNone;
        x_q_rs_valid_i = 3'b000;
        c_q_ready_i    = 2'b11;
        #1;
        checks++;
        if (x_q_ready_o !== 1'b1 || x_k_accept_o !== 1'b0 || c_q_valid_o !== 2'b00) begin
            failures++;
            $display("[TB] FAIL nomatch: ready=%b accept=%b c_q_valid=%b, expected 1 0 00",
                     x_q_ready_o, x_k_accept_o, c_q_valid_o);
        end
        @(posedge clk_i);
        #1;
        driveIdle();
        checks++;
        if (dut.r_cnt[0] !== 3'd1 || dut.r_cnt[1] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL nomatch_cnt: cnt0=%0d cnt1=%0d, expected 1 0",
                     dut.r_cnt[0], dut.r_cnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        x_p_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            x_q_valid_i    = 1'b1;
            x_q_instr_i    = InstrCh0;
            x_q_rs_valid_i = 3'b111;
            c_q_ready_i    = 2'b01;
            #1;
            checks++;
            if (x_q_ready_o !== ((k < 4) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, x_q_ready_o, (k < 4));
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        c_p_valid_i      = 2'b01;
        c_p_rd_i[4:0]    = 5'd7;
        c_p_data_i[31:0] = 32'hCAFE_0001;
        #1;
        checks++;
        if (x_q_ready_o !== 1'b0 || c_p_ready_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL b2b_rsp: ready=%b c_p_ready=%b, expected 0 01", x_q_ready_o, c_p_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        c_p_valid_i = 2'b00;
        #1;
        checks++;
        if (x_q_ready_o !== 1'b1 || x_p_valid_o !== 1'b1 || x_p_data_o !== 32'hCAFE_0001
            || x_p_rd_o !== 5'd7) begin
            failures++;
            $display("[TB] FAIL b2b_release: ready=%b x_p_valid=%b data=%h rd=%0d, expected 1 1 cafe0001 7",
                     x_q_ready_o, x_p_valid_o, x_p_data_o, x_p_rd_o);
        end
        @(posedge clk_i);
        #1;
        driveIdle();
        checks++;
        if (dut.r_cnt[0] !== 3'd4) begin
            failures++;
            $display("[TB] FAIL b2b_cnt0: got %0d expected 4", dut.r_cnt[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  expGnt  [4];
        logic [31:0] expData [4];
        expGnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        expData = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        applyReset();
        issue(InstrCh0, 2'b01);
        issue(InstrCh0, 2'b01);
        issue(InstrCh0, 2'b01);
        issue(InstrCh1, 2'b10);
        issue(InstrCh1, 2'b10);
        @(negedge clk_i);
        x_p_ready_i = 1'b1;
        c_p_valid_i = 2'b11;
        c_p_data_i  = {32'hB0, 32'hA0};
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (c_p_ready_o !== expGnt[k]) begin
                failures++;
                $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, c_p_ready_o, expGnt[k]);
            end
            if (k > 0) begin
                checks++;
                if (x_p_valid_o !== 1'b1 || x_p_data_o !== expData[k-1]) begin
                    failures++;
                    $display("[TB] FAIL rr_data[%0d]: valid=%b data=%h expected 1 %h",
                             k - 1, x_p_valid_o, x_p_data_o, expData[k-1]);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
            if (expGnt[k] == 2'b01) begin
                c_p_data_i[31:0] = 32'hA1;
            end else begin
                c_p_data_i[63:32] = 32'hB1;
            end
        end
        c_p_valid_i = 2'b00;
        #1;
        checks++;
        if (x_p_valid_o !== 1'b1 || x_p_data_o !== expData[3]) begin
            failures++;
            $display("[TB] FAIL rr_data[3]: valid=%b data=%h expected 1 %h", x_p_valid_o, x_p_data_o, expData[3]);
        end
        @(posedge clk_i);
        #1;
        driveIdle();
    endtask

    task automatic test_fifo_full();
        applyReset();
        issue(InstrCh0, 2'b01);
        issue(InstrCh0, 2'b01);
        issue(InstrCh0, 2'b01);
        @(negedge clk_i);
        x_p_ready_i      = 1'b0;
        c_p_valid_i      = 2'b01;
        c_p_rd_i[4:0]    = 5'd1;
        c_p_data_i[31:0] = 32'h1000_0000;
        c_p_error_i[0]   = 1'b0;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL full_push0: c_p_ready=%b expected 01", c_p_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        c_p_rd_i[4:0]    = 5'd2;
        c_p_data_i[31:0] = 32'h1000_0001;
        c_p_error_i[0]   = 1'b1;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b01 || x_p_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_push1: c_p_ready=%b x_p_valid=%b expected 01 1", c_p_ready_o, x_p_valid_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        c_p_rd_i[4:0]    = 5'd3;
        c_p_data_i[31:0] = 32'h1000_0002;
        c_p_error_i[0]   = 1'b0;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b00 || x_p_data_o !== 32'h1000_0000 || x_p_rd_o !== 5'd1) begin
            failures++;
            $display("[TB] FAIL full_stall: c_p_ready=%b data=%h rd=%0d expected 00 10000000 1",
                     c_p_ready_o, x_p_data_o, x_p_rd_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        x_p_ready_i = 1'b1;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b01 || x_p_data_o !== 32'h1000_0000) begin
            failures++;
            $display("[TB] FAIL full_pushpop: c_p_ready=%b data=%h expected 01 10000000", c_p_ready_o, x_p_data_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        c_p_valid_i = 2'b00;
        #1;
        checks++;
        if (x_p_data_o !== 32'h1000_0001 || x_p_error_o !== 1'b1 || x_p_rd_o !== 5'd2) begin
            failures++;
            $display("[TB] FAIL full_head1: data=%h err=%b rd=%0d expected 10000001 1 2",
                     x_p_data_o, x_p_error_o, x_p_rd_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (x_p_valid_o !== 1'b1 || x_p_data_o !== 32'h1000_0002 || x_p_error_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_head2: valid=%b data=%h err=%b expected 1 10000002 0",
                     x_p_valid_o, x_p_data_o, x_p_error_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (x_p_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_drained: x_p_valid=%b expected 0", x_p_valid_o);
        end
        driveIdle();
    endtask

    task automatic test_reset_midop();
        applyReset();
        for (int k = 0; k < 4; k++) begin
            issue(InstrCh0, 2'b01);
        end
        @(negedge clk_i);
        x_p_ready_i      = 1'b0;
        c_p_valid_i      = 2'b01;
        c_p_data_i[31:0] = 32'h0000_DEAD;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL midrst_rsp: c_p_ready=%b expected 01", c_p_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        c_p_valid_i = 2'b00;
        #1;
        checks++;
        if (x_p_valid_o !== 1'b1 || dut.r_cnt[0] !== 3'd3) begin
            failures++;
            $display("[TB] FAIL midrst_pre: x_p_valid=%b cnt0=%0d expected 1 3", x_p_valid_o, dut.r_cnt[0]);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (x_p_valid_o !== 1'b0 || dut.r_cnt[0] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midrst_post: x_p_valid=%b cnt0=%0d expected 0 0", x_p_valid_o, dut.r_cnt[0]);
        end
        rst_i = 1'b0;
        issue(InstrCh1, 2'b10);
        issue(InstrCh0, 2'b01);
        @(negedge clk_i);
        x_p_ready_i = 1'b1;
        c_p_valid_i = 2'b11;
        #1;
        checks++;
        if (c_p_ready_o !== 2'b01) begin
            failures++;
            $display("[TB] FAIL midrst_grant: c_p_ready=%b expected 01", c_p_ready_o);
        end
        @(posedge clk_i);
        #1;
        driveIdle();
    endtask

    initial begin
        test_reset();
        test_offload_hit();
        test_no_match();
        test_back_to_back();
        test_round_robin();
        test_fifo_full();
        test_reset_midop();
        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
